// File: rtl/mult_cell_seq_ctrl_if.sv
// rtl/mult_cell_seq_ctrl_if.sv - request/response handshake bundle for the multiplier sequencer
interface mult_cell_seq_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;

    modport master (
        output req_valid,
        input  req_ready,
        output req_op,
        output req_a,
        output req_b,
        input  resp_valid,
        output resp_ready,
        input  resp_result
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_op,
        input  req_a,
        input  req_b,
        output resp_valid,
        input  resp_ready,
        output resp_result
    );
endinterface

// File: rtl/mult_cell_seq_ctrl.sv
// rtl/mult_cell_seq_ctrl.sv - sequencer driving the 3-product 16x16 cell for 32x32 MUL/MULX
// Optional zero-operand bypass: MULT_CTRL_ZERO_SKIP_EN
module mult_cell_seq_ctrl #(
    parameter int STAT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mult_cell_seq_ctrl_if.slave  req_if,
    output logic [31:0]          cell_src1,
    output logic [31:0]          cell_src2,
    output logic                 cell_en,
    input  logic [31:0]          cell_p1,
    input  logic [31:0]          cell_p2,
    input  logic [31:0]          cell_p3,
    output logic                 busy,
    output logic [STAT_W-1:0]    op_count
);

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] OP_MULXSS = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_LO,
        S_CAP_LO,
        S_ISSUE_HI,
        S_CAP_HI,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]        op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       src1_q;
    logic [31:0]       src2_q;
    logic [16:0]       lo_acc_hi;
    logic [31:0]       result_q;
    logic [STAT_W-1:0] count_q;

    logic              zero_operand;
    logic [32:0]       mid_sum;
    logic [48:0]       lo_sum;
    logic [31:0]       hi_u;
    logic [31:0]       corr_a;
    logic [31:0]       corr_b;
    logic [31:0]       hi_res;

`ifdef MULT_CTRL_ZERO_SKIP_EN
    assign zero_operand = (req_if.req_a == 32'd0) || (req_if.req_b == 32'd0);
`else
    assign zero_operand = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_if.req_valid) begin
                    state_next = zero_operand ? S_DONE : S_ISSUE_LO;
                end
            end
            S_ISSUE_LO: state_next = (op_q == OP_MUL) ? S_CAP_LO : S_ISSUE_HI;
            S_CAP_LO:   state_next = S_DONE;
            S_ISSUE_HI: state_next = S_CAP_HI;
            S_CAP_HI:   state_next = S_DONE;
            S_DONE: begin
                if (req_if.resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default:    state_next = S_IDLE;
        endcase
    end

    // Low partial sum of the three cross products; 33-bit middle term keeps the carry.
    always_comb begin
        mid_sum = {1'b0, cell_p2} + {1'b0, cell_p3};
        lo_sum  = {17'd0, cell_p1} + {mid_sum, 16'd0};
    end

    // Only bits [48:32] of the low accumulator reach the high word; hh lands on bit 32.
    always_comb begin
        hi_u   = {15'd0, lo_acc_hi} + cell_p1;
        corr_a = ((op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[31]) ? b_q : 32'd0;
        corr_b = ((op_q == OP_MULXSS) && b_q[31]) ? a_q : 32'd0;
        hi_res = hi_u - corr_a - corr_b;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= OP_MUL;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            src1_q    <= 32'd0;
            src2_q    <= 32'd0;
            lo_acc_hi <= 17'd0;
            result_q  <= 32'd0;
            count_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_if.req_valid) begin
                        op_q <= req_if.req_op;
                        a_q  <= req_if.req_a;
                        b_q  <= req_if.req_b;
                        if (zero_operand) begin
                            result_q <= 32'd0;
                        end else begin
                            src1_q <= req_if.req_a;
                            src2_q <= req_if.req_b;
                        end
                    end
                end
                S_ISSUE_LO: begin
                    if (op_q != OP_MUL) begin
                        src1_q <= {16'd0, a_q[31:16]};
                        src2_q <= {16'd0, b_q[31:16]};
                    end
                end
                S_CAP_LO: begin
                    result_q <= lo_sum[31:0];
                end
                S_ISSUE_HI: begin
                    lo_acc_hi <= lo_sum[48:32];
                end
                S_CAP_HI: begin
                    result_q <= hi_res;
                end
                S_DONE: begin
                    if (req_if.resp_ready && (count_q != {STAT_W{1'b1}})) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_if.req_ready   = (state == S_IDLE);
    assign req_if.resp_valid  = (state == S_DONE);
    assign req_if.resp_result = result_q;
    assign cell_en            = (state == S_ISSUE_LO) || (state == S_ISSUE_HI);
    assign cell_src1          = src1_q;
    assign cell_src2          = src2_q;
    assign busy               = (state != S_IDLE);
    assign op_count           = count_q;

endmodule

// File: tb/tb_mult_cell_seq_ctrl.sv
// tb/tb_mult_cell_seq_ctrl.sv - scoreboard bench with a behavioural cell and 64-bit product model
module tb_mult_cell_seq_ctrl;
    localparam int STAT_W = 2;
`ifdef MULT_CTRL_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       cell_src1;
    logic [31:0]       cell_src2;
    logic              cell_en;
    logic [31:0]       cell_p1 = 32'd0;
    logic [31:0]       cell_p2 = 32'd0;
    logic [31:0]       cell_p3 = 32'd0;
    logic              busy;
    logic [STAT_W-1:0] op_count;

    mult_cell_seq_ctrl_if bus ();

    mult_cell_seq_ctrl #(.STAT_W(STAT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_if    (bus.slave),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          en_total = 0;
    int          model_count = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered cell: products update only on edges where the enable is high
    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= 32'(cell_src1[15:0]) * 32'(cell_src2[15:0]);
            cell_p2 <= 32'(cell_src1[15:0]) * 32'(cell_src2[31:16]);
            cell_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
        end
    end

    always @(negedge clk) begin
        if (cell_en) en_total++;
        if (reset_n && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=0x%0h expected=none", bus.resp_result);
            end else begin
                check("resp_result", 64'(bus.resp_result), 64'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] prod;
        ea   = ((op == 2'd2 || op == 2'd3) && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
        eb   = (op == 2'd3 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
        prod = ea * eb;
        return (op == 2'd0) ? prod[31:0] : prod[63:32];
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input bit pulse, input string tag);
        int          lat;
        int          en_start;
        int          exp_lat;
        int          exp_en;
        bit          skip;
        logic [31:0] held;
        skip    = ZS && (a == 32'd0 || b == 32'd0);
        exp_lat = skip ? 0 : ((op == 2'd0) ? 2 : 3);
        exp_en  = skip ? 0 : ((op == 2'd0) ? 1 : 2);
        check({tag, "_ready_idle"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.resp_ready = 1'b0;
        en_start       = en_total;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        bus.req_op    = 2'($urandom_range(0, 3));
        exp_q.push_back(ref_result(op, a, b));
        lat = 0;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        for (int i = 0; i < stall; i++) begin
            held = bus.resp_result;
            if (pulse && i == 1) bus.req_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            check({tag, "_stall_result"}, 64'(bus.resp_result), 64'(held));
            check({tag, "_stall_ready"}, 64'({bus.req_ready, bus.resp_valid, busy}), 64'(3'b011));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        if (model_count < (1 << STAT_W) - 1) model_count++;
        check({tag, "_op_count"}, 64'(op_count), 64'(model_count));
        check({tag, "_cell_en_cycles"}, 64'(en_total - en_start), 64'(exp_en));
        check({tag, "_back_idle"}, 64'({bus.req_ready, bus.resp_valid, busy}), 64'(3'b100));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
        check({tag, "_resp"}, 64'({bus.resp_valid, bus.resp_result}), 64'd0);
        check({tag, "_cell"}, {cell_en, cell_src1, cell_src2[30:0]}, 64'd0);
        check({tag, "_busy_cnt"}, 64'({busy, op_count}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] corner [4];
        logic [31:0] ra;
        logic [31:0] rb;
        corner[0] = 32'd0;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(2'd0, 32'h0001_0003, 32'h0002_0005, 0, 1'b0, "mul_vec");
        check("mul_vec_model", 64'(ref_result(2'd0, 32'h0001_0003, 32'h0002_0005)), 64'h000B_000F);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "mulxuu_ones");
        do_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "mulxss_ones");
        do_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "mulxsu_ones");
        do_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b1, "backpressure");
        do_op(2'd3, 32'h0000_0000, 32'h8000_0000, 0, 1'b0, "zero_op");

        // Abort a MULX in its second issue cycle
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd1;
        bus.req_a     = 32'hDEAD_BEEF;
        bus.req_b     = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_issue_hi", 64'({cell_en, busy}), 64'(2'b11));
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        model_count = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_resp", 64'(bus.resp_valid), 64'd0);
        do_op(2'd2, 32'h8000_0001, 32'h0000_FFFF, 1, 1'b0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            do_op(2'($urandom_range(0, 3)), ra, rb, $urandom_range(0, 2), 1'b1, "rand");
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
